// File: rtl/axistream_out_uart_core_pkg.sv
// Shared constants and FSM encodings for the axistream_out 8N1 UART core.
// Both the TX and RX state machines use the same four-phase frame encoding.
package axistream_out_uart_core_pkg;

  localparam int DEFAULT_DIV_W = 16;
  localparam int DATA_BITS     = 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/axistream_out_uart_core_if.sv
// Register-style byte backend between the CSR wrapper (master) and the UART core (slave).
interface axistream_out_uart_core_if;
  import axistream_out_uart_core_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 data_write_en;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_read_en;
  logic                 rx_ready;

  modport master (
    output tx_data, data_write_en, data_read_en,
    input  tx_ready, rx_data, rx_ready
  );

  modport slave (
    input  tx_data, data_write_en, data_read_en,
    output tx_ready, rx_data, rx_ready
  );
endinterface

// File: rtl/axistream_out_uart_core_bit_timer.sv
// Loadable down-counter: a load starts a first interval of load_val_i cycles, after which
// it pulses tc_o and reloads itself with period_i for every following interval.
module axistream_out_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i - 1'b1;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        tc_o  = 1'b1;
        cnt_d = period_i - 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axistream_out_uart_core.sv
// Full-duplex 8N1 UART core with RTS/CTS flow control and a register-style byte backend.
// TX and RX run independent FSMs, each paced by its own bit timer.
module axistream_out_uart_core
  import axistream_out_uart_core_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst_soft_i,
  input  logic             tx_en_i,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] bit_duration_i,
  output logic             txd_o,
  input  logic             rxd_i,
  output logic             rts_o,
  input  logic             cts_i,
  axistream_out_uart_core_if.slave bus_if
);

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic        txd_q, txd_d, tx_ready_q, tx_ready_d, rx_ready_q, rx_ready_d;
  logic        cts_meta_q, cts_sync_q, rxd_meta_q, rxd_sync_q, rxd_prev_q, rts_q;
  logic        tx_load, tx_tc, rx_load, rx_tc, rx_done;

  // Synchronizers idle at the line's idle level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rts_q      <= 1'b0;
    end else if (rst_soft_i) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rts_q      <= 1'b0;
    end else begin
      cts_meta_q <= cts_i;
      cts_sync_q <= cts_meta_q;
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rts_q      <= rx_en_i;
    end
  end

  axistream_out_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk(clk), .rst_n(rst_n), .clear_i(rst_soft_i), .load_i(tx_load),
    .en_i(tx_state_q != ST_IDLE), .load_val_i(bit_duration_i),
    .period_i(bit_duration_i), .tc_o(tx_tc)
  );

  // RX first interval is half a bit so every later sample lands mid-bit.
  axistream_out_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk(clk), .rst_n(rst_n), .clear_i(rst_soft_i), .load_i(rx_load),
    .en_i(rx_state_q != ST_IDLE), .load_val_i(bit_duration_i >> 1),
    .period_i(bit_duration_i), .tc_o(rx_tc)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    tx_ready_d = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d      = 1'b1;
        tx_ready_d = tx_en_i & cts_sync_q;
        if (bus_if.data_write_en && tx_ready_q) begin
          tx_shift_d = bus_if.tx_data;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = ST_START;
        end
      end
      ST_START: if (tx_tc) begin
        txd_d      = tx_shift_q[0];
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_tc) begin
        if (tx_bit_q == LAST_BIT) begin
          txd_d      = 1'b1;
          tx_state_d = ST_STOP;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          txd_d      = tx_shift_q[1];
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      ST_STOP: if (tx_tc) tx_state_d = ST_IDLE;
      default: tx_state_d = ST_IDLE;
    endcase
    if (rst_soft_i) begin
      tx_state_d = ST_IDLE;
      tx_shift_d = '0;
      tx_bit_d   = '0;
      txd_d      = 1'b1;
      tx_load    = 1'b0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_load    = 1'b0;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (rxd_prev_q && !rxd_sync_q) begin
        rx_load    = 1'b1;
        rx_state_d = ST_START;
      end
      ST_START: if (rx_tc) begin
        rx_bit_d   = '0;
        rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_tc) begin
        rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
        else                      rx_bit_d   = rx_bit_q + 3'd1;
      end
      ST_STOP: if (rx_tc) begin
        rx_state_d = ST_IDLE;
        if (rxd_sync_q) begin
          rx_data_d = rx_shift_q;
          rx_done   = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
    if (!rx_en_i) begin
      rx_state_d = ST_IDLE;
      rx_load    = 1'b0;
      rx_done    = 1'b0;
      rx_data_d  = rx_data_q;
    end
    // A byte completing in the same cycle as a read must remain visible.
    rx_ready_d = rx_ready_q;
    if (bus_if.data_read_en) rx_ready_d = 1'b0;
    if (rx_done)             rx_ready_d = 1'b1;
    if (rst_soft_i) begin
      rx_state_d = ST_IDLE;
      rx_shift_d = '0;
      rx_bit_d   = '0;
      rx_data_d  = '0;
      rx_ready_d = 1'b0;
      rx_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b0;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign txd_o           = txd_q;
  assign rts_o           = rts_q;
  assign bus_if.tx_ready = tx_ready_q;
  assign bus_if.rx_data  = rx_data_q;
  assign bus_if.rx_ready = rx_ready_q;

endmodule

// File: tb/tb_axistream_out_uart_core.sv
// Loopback bench for axistream_out_uart_core: a monitor pops expected RX bytes from a
// scoreboard queue and acknowledges them, while the stimulus process drives directed tests.
module tb_axistream_out_uart_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rstSoft = 1'b0;
  logic        txEn = 1'b0;
  logic        rxEn = 1'b0;
  logic [15:0] bitDuration = 16'd100;
  logic        txd, rts, rxd, cts;
  logic        loopback = 1'b1;
  logic        rxdDrv = 1'b1;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  sbQ[$];
  bit          monEnable = 1'b1;

  axistream_out_uart_core_if busIf ();

  assign rxd = loopback ? txd : rxdDrv;
  assign cts = rts;

  always #5 clk = ~clk;

  axistream_out_uart_core #(.DIV_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_soft_i    (rstSoft),
    .tx_en_i       (txEn),
    .rx_en_i       (rxEn),
    .bit_duration_i(bitDuration),
    .txd_o         (txd),
    .rxd_i         (rxd),
    .rts_o         (rts),
    .cts_i         (cts),
    .bus_if        (busIf)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic failTimeout(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out waiting, expected event within budget", name);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    busIf.tx_data       = b;
    busIf.data_write_en = 1'b1;
    @(negedge clk);
    busIf.data_write_en = 1'b0;
  endtask

  task automatic waitTxReady(input string name, input int maxCycles);
    int n = 0;
    while (busIf.tx_ready !== 1'b1 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (busIf.tx_ready !== 1'b1) failTimeout(name);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) failTimeout(name);
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxdDrv = bits[k];
      repeat (int'(bitDuration)) @(negedge clk);
    end
    rxdDrv = 1'b1;
  endtask

  // Scoreboard monitor: any unread byte is compared against the queue head and acknowledged.
  initial begin
    logic [7:0] exp;
    busIf.data_read_en = 1'b0;
    forever begin
      @(negedge clk);
      if (monEnable && busIf.rx_ready === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL rx_unexpected: got byte 0x%0h, expected none", busIf.rx_data);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("rx_data", {24'd0, busIf.rx_data}, {24'd0, exp});
        end
        busIf.data_read_en = 1'b1;
        @(negedge clk);
        busIf.data_read_en = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] frameA5;
    bit         txdStayedHigh;
    int         lat;

    busIf.tx_data       = 8'h00;
    busIf.data_write_en = 1'b0;

    // Reset and idle state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("reset_tx_ready", {31'd0, busIf.tx_ready}, 32'd0);
    checkOutput("reset_rx_ready", {31'd0, busIf.rx_ready}, 32'd0);
    checkOutput("reset_txd", {31'd0, txd}, 32'd1);
    checkOutput("reset_rts", {31'd0, rts}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, busIf.rx_data}, 32'd0);

    // Flow control: without rts/cts the transmitter must refuse writes
    txEn = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("flow_tx_ready_blocked", {31'd0, busIf.tx_ready}, 32'd0);
    applyStimulus(8'h77);
    txdStayedHigh = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) txdStayedHigh = 1'b0;
      @(negedge clk);
    end
    checkOutput("flow_write_ignored_txd", {31'd0, txdStayedHigh}, 32'd1);
    rxEn = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (busIf.tx_ready === 1'b1) break;
    end
    checks++;
    if (busIf.tx_ready === 1'b1 && lat <= 4) passes++;
    else $display("[TB] FAIL flow_tx_ready_latency: got %0d cycles (tx_ready=%b), expected <=4 with tx_ready=1",
                  lat, busIf.tx_ready);
    checkOutput("flow_rts", {31'd0, rts}, 32'd1);

    // Single byte 0xA5, bit-exact line check
    frameA5 = 10'b1_1010_0101_0;
    sbQ.push_back(8'hA5);
    applyStimulus(8'hA5);
    checkOutput("single_tx_ready_drop", {31'd0, busIf.tx_ready}, 32'd0);
    repeat (50) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("single_txd_bit%0d", k), {31'd0, txd}, {31'd0, frameA5[k]});
      repeat (100) @(negedge clk);
    end
    waitDrain("single_rx_drain", 1500);
    checkOutput("single_rx_ready_cleared", {31'd0, busIf.rx_ready}, 32'd0);

    // Exhaustive loopback at the minimum bit period
    txEn = 1'b0;
    rxEn = 1'b0;
    repeat (5) @(negedge clk);
    bitDuration = 16'd4;
    txEn = 1'b1;
    rxEn = 1'b1;
    for (int b = 0; b < 256; b++) begin
      waitTxReady("exh_tx_ready", 100);
      sbQ.push_back(8'(b));
      applyStimulus(8'(b));
    end
    waitDrain("exh_rx_drain", 200);

    // Overrun: second byte overwrites the unread first one
    txEn = 1'b0;
    rxEn = 1'b0;
    repeat (5) @(negedge clk);
    bitDuration = 16'd100;
    monEnable = 1'b0;
    txEn = 1'b1;
    rxEn = 1'b1;
    waitTxReady("ovr_tx_ready0", 20);
    applyStimulus(8'h11);
    waitTxReady("ovr_tx_ready1", 1200);
    applyStimulus(8'h22);
    waitTxReady("ovr_tx_ready2", 1200);
    checkOutput("ovr_rx_ready", {31'd0, busIf.rx_ready}, 32'd1);
    checkOutput("ovr_rx_data", {24'd0, busIf.rx_data}, 32'h22);

    // Soft reset in the middle of a frame (0x33: bit 2 is low)
    applyStimulus(8'h33);
    repeat (300) @(negedge clk);
    checkOutput("srst_pre_txd", {31'd0, txd}, 32'd0);
    rstSoft = 1'b1;
    @(negedge clk);
    rstSoft = 1'b0;
    checkOutput("srst_txd", {31'd0, txd}, 32'd1);
    checkOutput("srst_rx_ready", {31'd0, busIf.rx_ready}, 32'd0);
    checkOutput("srst_tx_ready", {31'd0, busIf.tx_ready}, 32'd0);
    checkOutput("srst_rx_data", {24'd0, busIf.rx_data}, 32'd0);
    monEnable = 1'b1;
    waitTxReady("srst_recover", 20);

    // Glitch on the line must not start a reception
    loopback = 1'b0;
    repeat (5) @(negedge clk);
    rxdDrv = 1'b0;
    repeat (10) @(negedge clk);
    rxdDrv = 1'b1;
    repeat (1200) @(negedge clk);
    checkOutput("glitch_rx_ready", {31'd0, busIf.rx_ready}, 32'd0);

    // Framing error discards the byte, a following good frame is received
    sendFrame(8'h5A, 1'b0);
    repeat (300) @(negedge clk);
    checkOutput("framing_rx_ready", {31'd0, busIf.rx_ready}, 32'd0);
    sbQ.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1);
    waitDrain("manual_rx_drain", 300);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
